// File: rtl/ps2_host_rx.sv
// PS/2 device-to-host receiver: synchronises and de-glitches the link clock,
// deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop),
// checks them and queues good bytes in a first-word-fall-through FIFO
// that is drained on a valid/ready handshake.
module ps2_host_rx #(
    parameter int FIFO_BITS = 3,     // log2 FIFO depth, >= 1
    parameter int FILTER    = 4,     // equal samples to accept a new clk level, >= 1
    parameter int TIMEOUT   = 50000  // cycles without a falling edge before abort, >= 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int FCW   = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int TCW   = $clog2(TIMEOUT);
    localparam int DEPTH = 1 << FIFO_BITS;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic           clk_sync_p0, clk_sync_p1;
    logic           data_sync_p0, data_sync_p1;
    logic           clk_filt, clk_filt_d;
    logic [FCW-1:0] filt_cnt;
    logic           fe;
    logic           bit_in;

    state_t         state_q, state_nxt;
    logic [2:0]     bitcnt;
    logic [7:0]     shreg;
    logic           acc;
    logic           par_bit;
    logic           par_ok;
    logic [TCW-1:0] tcnt;
    logic           timeout_hit;

    logic           push_d, perr_d, ferr_d;
    logic           push_q, perr_q, ferr_q;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_BITS:0] wptr, rptr;
    logic               empty, full, pop, wr_en;

    // Two-flop synchronisers for both asynchronous link inputs
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            clk_sync_p0  <= 1'b1;
            clk_sync_p1  <= 1'b1;
            data_sync_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
        end else begin
            clk_sync_p0  <= ps2_clk;
            clk_sync_p1  <= clk_sync_p0;
            data_sync_p0 <= ps2_data;
            data_sync_p1 <= data_sync_p0;
        end
    end

    // Glitch filter: a new clk level is taken only after FILTER equal samples
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_sync_p1 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER - 1)) begin
                clk_filt <= clk_sync_p1;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FCW'(1);
            end
        end
    end

    assign fe     = clk_filt_d & ~clk_filt;
    assign bit_in = data_sync_p1;
    assign par_ok = ~(acc ^ par_bit);

    // Fires on the edge where the count reaches TIMEOUT-1, so the abort
    // pulse lands exactly TIMEOUT cycles after the last falling edge.
    assign timeout_hit = (state_q != IDLE) && !fe && (tcnt == TCW'(TIMEOUT - 2));

    // FSM state register
    always_ff @(posedge clk_sys) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_nxt;
    end

    // FSM next state: advances only on a filtered falling edge or a timeout
    always_comb begin
        state_nxt = state_q;
        if (timeout_hit) begin
            state_nxt = IDLE;
        end else if (fe) begin
            case (state_q)
                IDLE:    if (!bit_in) state_nxt = DATA;
                DATA:    if (bitcnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs: frame verdict at the stop bit, one outcome per frame
    always_comb begin
        push_d = 1'b0;
        perr_d = 1'b0;
        ferr_d = timeout_hit;
        busy   = (state_q != IDLE);
        if (fe && state_q == STOP) begin
            if (!bit_in)     ferr_d = 1'b1;
            else if (par_ok) push_d = 1'b1;
            else             perr_d = 1'b1;
        end
    end

    // Bit counter, parity accumulator and stored parity bit
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            bitcnt  <= '0;
            acc     <= 1'b1;
            par_bit <= 1'b0;
        end else if (fe) begin
            case (state_q)
                IDLE: begin
                    bitcnt <= '0;
                    acc    <= 1'b1;
                end
                DATA: begin
                    bitcnt <= bitcnt + 3'd1;
                    acc    <= acc ^ bit_in;
                end
                PARITY:  par_bit <= bit_in;
                default: ;
            endcase
        end
    end

    // Data shift register, LSB arrives first so bits enter at the top
    always_ff @(posedge clk_sys) begin
        if (fe && state_q == DATA) shreg <= {bit_in, shreg[7:1]};
    end

    // Inactivity counter, held at zero while idle and on every falling edge
    always_ff @(posedge clk_sys) begin
        if (!reset_n || state_q == IDLE || fe) tcnt <= '0;
        else                                   tcnt <= tcnt + TCW'(1);
    end

    // Registered verdict pulses, one cycle after the deciding edge
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            push_q <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            push_q <= push_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
        end
    end

    assign empty    = (wptr == rptr);
    assign full     = (wptr[FIFO_BITS-1:0] == rptr[FIFO_BITS-1:0]) &&
                      (wptr[FIFO_BITS] != rptr[FIFO_BITS]);
    assign rx_valid = !empty;
    assign pop      = rx_valid & rx_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign wr_en    = push_q & (!full | pop);

    // FIFO storage, shreg is still stable in the push cycle
    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[wptr[FIFO_BITS-1:0]] <= shreg;
    end

    // FIFO pointers with an extra wrap bit to tell full from empty
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
        end
    end

    assign rx_data    = empty ? 8'h00 : mem[rptr[FIFO_BITS-1:0]];
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = push_q & full & ~pop;

endmodule
